// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format codes, base
// opcodes and the RVC {quadrant, funct3} keys.
package imm_pkg;

  // Ten formats plus NONE need four bits.
  typedef enum logic [3:0] {
    FMT_NONE = 4'd0,
    FMT_I    = 4'd1,
    FMT_S    = 4'd2,
    FMT_B    = 4'd3,
    FMT_U    = 4'd4,
    FMT_J    = 4'd5,
    FMT_Z    = 4'd6,
    FMT_CI   = 4'd7,
    FMT_CB   = 4'd8,
    FMT_CJ   = 4'd9,
    FMT_CLS  = 4'd10
  } imm_fmt_e;

  localparam int FMT_W = 4;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // RVC keys are {inst[1:0], inst[15:13]}.
  localparam logic [4:0] C_LW   = 5'b00_010;
  localparam logic [4:0] C_SW   = 5'b00_110;
  localparam logic [4:0] C_ADDI = 5'b01_000;
  localparam logic [4:0] C_LI   = 5'b01_010;
  localparam logic [4:0] C_LUI  = 5'b01_011;
  localparam logic [4:0] C_J    = 5'b01_101;
  localparam logic [4:0] C_BEQZ = 5'b01_110;
  localparam logic [4:0] C_BNEZ = 5'b01_111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Bundle handshake between fetch/decode and the immediate generator.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LANES = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0]            in_lane_vld;
  logic [LANES-1:0][31:0]      in_inst;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0]            out_lane_vld;
  logic [LANES-1:0][XLEN-1:0]  out_imm;
  imm_fmt_e [LANES-1:0]        out_fmt;
  logic [LANES-1:0]            out_unsup;

  modport slave (
    input  in_valid, in_lane_vld, in_inst, out_ready,
    output in_ready, out_valid, out_lane_vld, out_imm, out_fmt, out_unsup
  );

  modport master (
    output in_valid, in_lane_vld, in_inst, out_ready,
    input  in_ready, out_valid, out_lane_vld, out_imm, out_fmt, out_unsup
  );
endinterface

// File: rtl/imm_decode_lane.sv
// Combinational immediate decode for one instruction slot (RV32/64 base
// formats, CSR zimm and an RVC subset).
module imm_decode_lane
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_C = 1'b1
) (
  input  logic            vld,
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            unsup
);
  // Every immediate is first formed as a 32-bit value; zero-extended ones
  // never set bit 31, so one sign-extension covers both cases.
  logic [31:0] v;

  always_comb begin
    v     = '0;
    fmt   = FMT_NONE;
    unsup = 1'b0;
    if (vld) begin
      if (inst[1:0] == 2'b11) begin
        if (inst[4:2] == 3'b111) begin
          unsup = 1'b1;
        end else begin
          case (inst[6:0])
            OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_JALR: begin
              fmt = FMT_I;
              v   = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE, OPC_STORE_FP: begin
              fmt = FMT_S;
              v   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
              fmt = FMT_B;
              v   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
              fmt = FMT_U;
              v   = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
              fmt = FMT_J;
              v   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
              if (inst[14]) begin
                fmt = FMT_Z;
                v   = {27'b0, inst[19:15]};
              end
            end
            OPC_OP, OPC_OP_FP: ;
            default: unsup = 1'b1;
          endcase
        end
      end else if (!SUPPORT_C) begin
        unsup = 1'b1;
      end else begin
        case ({inst[1:0], inst[15:13]})
          C_LW, C_SW: begin
            fmt = FMT_CLS;
            v   = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
          end
          C_ADDI, C_LI: begin
            fmt = FMT_CI;
            v   = {{26{inst[12]}}, inst[12], inst[6:2]};
          end
          C_LUI: begin
            // rd=2 is C.ADDI16SP, which this subset does not cover.
            if (inst[11:7] == 5'd0 || inst[11:7] == 5'd2) begin
              unsup = 1'b1;
            end else begin
              fmt = FMT_CI;
              v   = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
            end
          end
          C_J: begin
            fmt = FMT_CJ;
            v   = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                   inst[2], inst[11], inst[5:3], 1'b0};
          end
          C_BEQZ, C_BNEZ: begin
            fmt = FMT_CB;
            v   = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
          end
          default: unsup = 1'b1;
        endcase
      end
    end
  end

  assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator: per-lane combinational decode, registered
// once into an output register backed by a one-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LANES     = 2,
  parameter bit SUPPORT_C = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [LANES-1:0]           lane_vld;
    logic [LANES-1:0][XLEN-1:0] imm;
    imm_fmt_e [LANES-1:0]       fmt;
    logic [LANES-1:0]           unsup;
  } bundle_t;

  logic [LANES-1:0][XLEN-1:0] dec_imm;
  imm_fmt_e [LANES-1:0]       dec_fmt;
  logic [LANES-1:0]           dec_unsup;
  bundle_t                    dec;

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic    acc, drain;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    imm_decode_lane #(
      .XLEN      (XLEN),
      .SUPPORT_C (SUPPORT_C)
    ) u_dec (
      .vld   (bus.in_lane_vld[g]),
      .inst  (bus.in_inst[g]),
      .imm   (dec_imm[g]),
      .fmt   (dec_fmt[g]),
      .unsup (dec_unsup[g])
    );
  end

  always_comb begin
    dec.lane_vld = bus.in_lane_vld;
    dec.imm      = dec_imm;
    dec.fmt      = dec_fmt;
    dec.unsup    = dec_unsup;
  end

  assign acc   = bus.in_valid & ~skid_vld_q;
  assign drain = out_vld_q & bus.out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (!out_vld_q || drain) begin
      // Output slot frees up: a held skid bundle has priority (and blocks acc).
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = acc;
        if (acc) out_d = dec;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_d     = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready     = ~skid_vld_q;
  assign bus.out_valid    = out_vld_q;
  assign bus.out_lane_vld = out_q.lane_vld;
  assign bus.out_imm      = out_q.imm;
  assign bus.out_fmt      = out_q.fmt;
  assign bus.out_unsup    = out_q.unsup;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (RV32+C, RV64+C, RV32 no C)
// driven with identical stimulus; directed vectors plus a random scoreboard.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [L-1:0]        in_lane_vld = '0;
  logic [L-1:0][31:0]  in_inst = '0;

  imm_gen_pipe_if #(.XLEN(32), .LANES(L)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .LANES(L)) b64 ();
  imm_gen_pipe_if #(.XLEN(32), .LANES(L)) bnc ();

  assign b32.in_valid = in_valid;  assign b32.out_ready = out_ready;
  assign b32.in_lane_vld = in_lane_vld;  assign b32.in_inst = in_inst;
  assign b64.in_valid = in_valid;  assign b64.out_ready = out_ready;
  assign b64.in_lane_vld = in_lane_vld;  assign b64.in_inst = in_inst;
  assign bnc.in_valid = in_valid;  assign bnc.out_ready = out_ready;
  assign bnc.in_lane_vld = in_lane_vld;  assign bnc.in_inst = in_inst;

  imm_gen_pipe #(.XLEN(32), .LANES(L), .SUPPORT_C(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .LANES(L), .SUPPORT_C(1'b1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));
  imm_gen_pipe #(.XLEN(32), .LANES(L), .SUPPORT_C(1'b0)) unc (.clk(clk), .rst_n(rst_n), .bus(bnc.slave));

  // Uniform taps: index 0 = RV32+C, 1 = RV64+C, 2 = RV32 without C.
  logic [63:0]  a_imm [3][L];
  imm_fmt_e     a_fmt [3][L];
  logic [L-1:0] a_uns [3];
  logic [L-1:0] a_lv  [3];
  logic         a_ov  [3];
  logic         a_ir  [3];

  for (genvar k = 0; k < L; k++) begin : g_tap
    assign a_imm[0][k] = 64'(b32.out_imm[k]);
    assign a_imm[1][k] = b64.out_imm[k];
    assign a_imm[2][k] = 64'(bnc.out_imm[k]);
    assign a_fmt[0][k] = b32.out_fmt[k];
    assign a_fmt[1][k] = b64.out_fmt[k];
    assign a_fmt[2][k] = bnc.out_fmt[k];
  end
  assign a_uns[0] = b32.out_unsup;    assign a_uns[1] = b64.out_unsup;    assign a_uns[2] = bnc.out_unsup;
  assign a_lv[0]  = b32.out_lane_vld; assign a_lv[1]  = b64.out_lane_vld; assign a_lv[2]  = bnc.out_lane_vld;
  assign a_ov[0]  = b32.out_valid;    assign a_ov[1]  = b64.out_valid;    assign a_ov[2]  = bnc.out_valid;
  assign a_ir[0]  = b32.in_ready;     assign a_ir[1]  = b64.in_ready;     assign a_ir[2]  = bnc.in_ready;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (field arithmetic) ----------------
  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    return longint'((w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  function automatic longint sx(input longint x, input int n);
    return (x >= (longint'(1) << (n - 1))) ? x - (longint'(1) << n) : x;
  endfunction

  task automatic ref_lane(input logic [31:0] w, input logic v, input bit c_en, input int xlen,
                          output logic [63:0] imm, output imm_fmt_e f, output logic u);
    longint val;
    val = 0; f = FMT_NONE; u = 1'b0;
    if (!v) begin
    end else if (w[1:0] == 2'b11) begin
      if (w[4:2] == 3'b111) u = 1'b1;
      else case (w[6:0])
        7'h03, 7'h07, 7'h13, 7'h67: begin f = FMT_I; val = sx(fld(w, 31, 20), 12); end
        7'h23, 7'h27: begin f = FMT_S; val = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12); end
        7'h63: begin
          f = FMT_B;
          val = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2, 13);
        end
        7'h37, 7'h17: begin f = FMT_U; val = sx(fld(w, 31, 12) * 4096, 32); end
        7'h6F: begin
          f = FMT_J;
          val = sx(fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048
                   + fld(w, 30, 21) * 2, 21);
        end
        7'h73: if (w[14]) begin f = FMT_Z; val = fld(w, 19, 15); end
        7'h33, 7'h53: ;
        default: u = 1'b1;
      endcase
    end else if (!c_en) begin
      u = 1'b1;
    end else begin
      case ({w[1:0], w[15:13]})
        5'b00_010, 5'b00_110: begin
          f = FMT_CLS; val = fld(w, 5, 5) * 64 + fld(w, 12, 10) * 8 + fld(w, 6, 6) * 4;
        end
        5'b01_000, 5'b01_010: begin f = FMT_CI; val = sx(fld(w, 12, 12) * 32 + fld(w, 6, 2), 6); end
        5'b01_011: begin
          if (fld(w, 11, 7) == 0 || fld(w, 11, 7) == 2) u = 1'b1;
          else begin f = FMT_CI; val = sx(fld(w, 12, 12) * 32 + fld(w, 6, 2), 6) * 4096; end
        end
        5'b01_101: begin
          f = FMT_CJ;
          val = sx(fld(w, 12, 12) * 2048 + fld(w, 11, 11) * 16 + fld(w, 10, 9) * 256 + fld(w, 8, 8) * 1024
                   + fld(w, 7, 7) * 64 + fld(w, 6, 6) * 128 + fld(w, 5, 3) * 2 + fld(w, 2, 2) * 32, 12);
        end
        5'b01_110, 5'b01_111: begin
          f = FMT_CB;
          val = sx(fld(w, 12, 12) * 256 + fld(w, 11, 10) * 8 + fld(w, 6, 5) * 64 + fld(w, 4, 3) * 2
                   + fld(w, 2, 2) * 32, 9);
        end
        default: u = 1'b1;
      endcase
    end
    imm = 64'(val);
    if (xlen == 32) imm[63:32] = '0;
  endtask

  typedef struct {
    logic [L-1:0][31:0] i;
    logic [L-1:0]       m;
  } ent_t;
  ent_t sb[$];

  task automatic cmp_out(input ent_t e);
    logic [63:0] imm;
    imm_fmt_e    f;
    logic        u;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rnd d%0d lane_vld", d), 128'(a_lv[d]), 128'(e.m));
      for (int k = 0; k < L; k++) begin
        ref_lane(e.i[k], e.m[k], d != 2, (d == 1) ? 64 : 32, imm, f, u);
        chk($sformatf("rnd d%0d l%0d inst=%h {fmt,unsup,imm}", d, k, e.i[k]),
            128'({a_fmt[d][k], a_uns[d][k], a_imm[d][k]}), 128'({f, u, imm}));
      end
    end
  endtask

  task automatic pop_check();
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL rnd_extra: output bundle with empty scoreboard");
    end else begin
      cmp_out(sb.pop_front());
    end
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  ops [15] = '{7'h03, 7'h07, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37,
                              7'h63, 7'h67, 7'h6F, 7'h73, 7'h53, 7'h0F, 7'h1B};
    r = $urandom;
    case ($urandom % 3)
      0:       return r;
      1:       return {r[31:7], ops[$urandom % 15]};
      default: return {r[31:2], 2'($urandom % 3)};
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    int          sel;
    logic [31:0] i0, i1;
    logic [1:0]  m;
    logic [63:0] e0, e1;
    imm_fmt_e    f0, f1;
    logic [1:0]  u;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [63:0] got[$];

    tbl[0]  = '{0, 32'hFFF00093, 32'h123450B7, 2'b11, 64'hFFFFFFFF, 64'h12345000, FMT_I, FMT_U, 2'b00};
    tbl[1]  = '{1, 32'hFE000EE3, 32'h3002D073, 2'b11, 64'hFFFFFFFFFFFFFFFC, 64'h5, FMT_B, FMT_Z, 2'b00};
    tbl[2]  = '{0, 32'h0000557D, 32'h00000013, 2'b11, 64'hFFFFFFFF, 64'h0, FMT_CI, FMT_I, 2'b00};
    tbl[3]  = '{2, 32'h0000557D, 32'h00000013, 2'b11, 64'h0, 64'h0, FMT_NONE, FMT_I, 2'b01};
    tbl[4]  = '{0, 32'h00000013, 32'hFFFFFFFF, 2'b01, 64'h0, 64'h0, FMT_I, FMT_NONE, 2'b00};
    tbl[5]  = '{0, 32'h00000013, 32'hFFFFFFFF, 2'b11, 64'h0, 64'h0, FMT_I, FMT_NONE, 2'b10};
    tbl[6]  = '{1, 32'h800000B7, 32'h00000033, 2'b11, 64'hFFFFFFFF80000000, 64'h0, FMT_U, FMT_NONE, 2'b00};
    tbl[7]  = '{0, 32'h0000BFFD, 32'h0000DC7D, 2'b11, 64'hFFFFFFFE, 64'hFFFFFFFE, FMT_CJ, FMT_CB, 2'b00};
    tbl[8]  = '{0, 32'h00005C60, 32'h00006105, 2'b11, 64'h7C, 64'h0, FMT_CLS, FMT_NONE, 2'b10};
    tbl[9]  = '{1, 32'h000070FD, 32'hFE112E23, 2'b11, 64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFFFFFFC, FMT_CI, FMT_S, 2'b00};
    tbl[10] = '{0, 32'h30029073, 32'h0000000F, 2'b11, 64'h0, 64'h0, FMT_NONE, FMT_NONE, 2'b10};

    // Reset state
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d {ov,ir,lv,uns}", d), 128'({a_ov[d], a_ir[d], a_lv[d], a_uns[d]}), 128'(6'b010000));
      chk($sformatf("reset d%0d imm/fmt", d), 128'({a_imm[d][0], a_imm[d][1], a_fmt[d][0], a_fmt[d][1]}), 128'(0));
    end
    rst_n = 1'b1;

    // Table: offer one bundle, check one cycle later
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      in_inst[0] = tbl[i].i0; in_inst[1] = tbl[i].i1; in_lane_vld = tbl[i].m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 128'(a_ov[tbl[i].sel]), 128'(1));
      chk($sformatf("vec%0d lane_vld", i), 128'(a_lv[tbl[i].sel]), 128'(tbl[i].m));
      chk($sformatf("vec%0d lane0", i), 128'({a_fmt[tbl[i].sel][0], a_uns[tbl[i].sel][0], a_imm[tbl[i].sel][0]}),
          128'({tbl[i].f0, tbl[i].u[0], tbl[i].e0}));
      chk($sformatf("vec%0d lane1", i), 128'({a_fmt[tbl[i].sel][1], a_uns[tbl[i].sel][1], a_imm[tbl[i].sel][1]}),
          128'({tbl[i].f1, tbl[i].u[1], tbl[i].e1}));
    end

    // Backpressure: three offers with out_ready low, only two fit
    acc = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_lane_vld = 2'b11;
      in_inst[0] = (32'(k) << 20) | 32'h13; in_inst[1] = 32'h13;
      @(negedge clk);
      if (a_ir[0]) acc++;
      if (k == 3) begin
        chk("bp in_ready on 3rd offer", 128'(a_ir[0]), 128'(0));
        chk("bp output held stable", 128'(a_imm[0][0]), 128'(1));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp accepted count", 128'(acc), 128'(2));
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (a_ov[0]) got.push_back(a_imm[0][0]);
    end
    chk("bp emerged count", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      chk("bp order first", 128'(got[0]), 128'(1));
      chk("bp order second", 128'(got[1]), 128'(2));
    end
    chk("bp in_ready restored", 128'(a_ir[0]), 128'(1));

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_lane_vld = L'($urandom);
      for (int k = 0; k < L; k++) in_inst[k] = gen_inst();
      @(negedge clk);
      if (a_ov[0] && out_ready) pop_check();
      if (in_valid && a_ir[0]) sb.push_back('{in_inst, in_lane_vld});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (a_ov[0]) pop_check();
      @(posedge clk); #1;
    end
    chk("rnd scoreboard drained", 128'(sb.size()), 128'(0));

    // Asynchronous reset with output and skid both full
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_lane_vld = 2'b11;
      in_inst[0] = 32'h123450B7; in_inst[1] = 32'hFFF00093;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full before reset {ov,ir}", 128'({a_ov[0], a_ir[0]}), 128'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset d%0d {ov,ir,lv,uns}", d), 128'({a_ov[d], a_ir[d], a_lv[d], a_uns[d]}), 128'(6'b010000));
      chk($sformatf("midreset d%0d imm/fmt", d), 128'({a_imm[d][0], a_imm[d][1], a_fmt[d][0], a_fmt[d][1]}), 128'(0));
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("after reset {ov,ir}", 128'({a_ov[0], a_ir[0]}), 128'(2'b01));
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; in_lane_vld = 2'b01; in_inst[0] = 32'hFFF00093;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-reset latency {ov,imm}", 128'({a_ov[0], a_imm[0][0]}), 128'({1'b1, 64'hFFFFFFFF}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
